// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB first, optional even parity, stop bit.
// Every bit is held for DIV clocks; all outputs are registered.
module uart_tx #(
  parameter int CLK_HZ    = 3125000,
  parameter int BAUD      = 115200,
  parameter int DIV       = CLK_HZ / BAUD,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state,  w_state_next;
  logic [CNT_W-1:0] r_baud,   w_baud_next;
  logic [2:0]       r_bit,    w_bit_next;
  logic [7:0]       r_shift,  w_shift_next;
  logic             r_parity, w_parity_next;
  logic             r_tx,     w_tx_next;
  logic             r_busy,   w_busy_next;
  logic             r_done,   w_done_next;
  logic             w_bit_end;

  assign w_bit_end = (r_baud == CNT_LAST);

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_baud   <= w_baud_next;
      r_bit    <= w_bit_next;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
      r_tx     <= w_tx_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = r_baud;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_tx_next     = r_tx;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;

    // Outside IDLE the baud counter wraps every DIV clocks; IDLE pins it to zero.
    if (r_state != S_IDLE) begin
      w_baud_next = w_bit_end ? '0 : r_baud + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        if (tx_start && !r_busy) begin
          w_shift_next  = tx_data;
          w_parity_next = ^tx_data;
          w_tx_next     = 1'b0;
          w_busy_next   = 1'b1;
          w_state_next  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_tx_next    = r_shift[7];
          w_bit_next   = 3'd7;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd0) begin
            w_tx_next    = PARITY_EN ? r_parity : 1'b1;
            w_state_next = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            // Shift left so the next outgoing bit always sits at r_shift[7].
            w_shift_next = {r_shift[6:0], 1'b0};
            w_tx_next    = r_shift[6];
            w_bit_next   = r_bit - 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_tx_next    = 1'b1;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus random bytes, compared
// cycle by cycle against a frame model built from the bit-sequence rules.
module tb_uart_tx;

  localparam int CLK_HZ = 3125000;
  localparam int BAUD   = 115200;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam bit P_EN   = 1'b1;
  localparam int NBITS  = P_EN ? 11 : 10;

  logic       clk_3125 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int tests = 0;
  int fails = 0;

  uart_tx #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .PARITY_EN(P_EN)
  ) dut (
    .clk_3125(clk_3125),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk_3125 = ~clk_3125;

  // Line level of bit slot idx in a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[8 - idx];
    if (P_EN && idx == 9) return (($countones(d) % 2) == 1);
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk_3125);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic got, input logic exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s @%0d: got %b expected %b", tag, k, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_tx", i, tx, 1'b1);
      chk("idle_busy", i, tx_busy, 1'b0);
      chk("idle_done", i, tx_done, 1'b0);
      tick();
    end
  endtask

  // Entered one step after the acceptance edge; returns one step after the frame-end edge.
  task automatic check_frame(input logic [7:0] d, input int inj, input logic [7:0] inj_d,
                             input bit hold);
    for (int k = 0; k < NBITS * DIV; k++) begin
      chk("tx", k, tx, exp_bit(d, k / DIV));
      chk("busy", k, tx_busy, 1'b1);
      chk("done", k, tx_done, 1'b0);
      if (k == inj) begin
        tx_start = 1'b1;
        tx_data  = inj_d;
      end else if (!hold) begin
        tx_start = 1'b0;
      end
      tick();
    end
    chk("end_done", NBITS * DIV, tx_done, 1'b1);
    chk("end_busy", NBITS * DIV, tx_busy, 1'b0);
    chk("end_tx", NBITS * DIV, tx, 1'b1);
    $display("[TB] frame %02h checked", d);
  endtask

  task automatic send(input logic [7:0] d, input int inj, input logic [7:0] inj_d,
                      input bit hold);
    tx_start = 1'b1;
    tx_data  = d;
    tick();
    if (!hold) tx_start = 1'b0;
    check_frame(d, inj, inj_d, hold);
  endtask

  initial begin
    logic [7:0] rd;
    int         gap;
    int         rinj;

    tick();
    tick();
    chk("rst_tx", 0, tx, 1'b1);
    chk("rst_busy", 0, tx_busy, 1'b0);
    chk("rst_done", 0, tx_done, 1'b0);
    rst_n = 1'b1;
    idle(100);

    send(8'hA5, -1, 8'h00, 1'b0);
    tick();
    idle(5);
    send(8'h07, -1, 8'h00, 1'b0);
    tick();
    idle(3);
    send(8'hCA, -1, 8'h00, 1'b0);
    tick();
    idle(3);

    // Start pulse while busy must be ignored; no second frame, single done.
    send(8'h3C, 99, 8'hFF, 1'b0);
    tick();
    idle(30);

    // Held start: data switched mid-frame, second frame follows one clock after done.
    send(8'h55, 100, 8'hAA, 1'b1);
    tick();
    tx_start = 1'b0;
    check_frame(8'hAA, -1, 8'h00, 1'b0);
    tick();
    idle(3);

    // Reset mid data bit (bit3 of F0 is 0 so the line visibly returns high).
    tx_start = 1'b1;
    tx_data  = 8'hF0;
    tick();
    tx_start = 1'b0;
    repeat (150) tick();
    chk("pre_rst_tx", 150, tx, 1'b0);
    chk("pre_rst_busy", 150, tx_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 0, tx, 1'b1);
    chk("async_rst_busy", 0, tx_busy, 1'b0);
    chk("async_rst_done", 0, tx_done, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("in_rst_tx", i, tx, 1'b1);
      chk("in_rst_done", i, tx_done, 1'b0);
    end
    #2 rst_n = 1'b1;
    tick();
    idle(20);
    send(8'h81, -1, 8'h00, 1'b0);
    tick();
    idle(2);

    for (int n = 0; n < 8; n++) begin
      rd   = 8'($urandom);
      gap  = $urandom_range(0, 20);
      rinj = $urandom_range(0, NBITS * DIV - 2);
      idle(gap);
      send(rd, rinj, 8'($urandom), 1'b0);
      tick();
      idle(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
